// File: rtl/pc_update.sv
// Fetch-stage PC register. Each cycle it loads the source named by PC_select
// as the next fetch PC and tracks the BOOT/RUN/HOLD state. It also produces
// registered redirect/flush/fetch_valid flags and a saturating hold-cycle
// counter. Every output comes straight from a flop.
module pc_update #(
   parameter int              PC_W        = 16,
   parameter int              FETCH_WIDTH = 4,
   parameter logic [PC_W-1:0] RESET_VEC   = '0,
   parameter int              STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             PC_select,
   input  logic [PC_W-1:0]        pc_pred0,
   input  logic [PC_W-1:0]        pc_pred1,
   input  logic [PC_W-1:0]        pc_jump,
   input  logic [PC_W-1:0]        pc_recovery,
   input  logic [PC_W-1:0]        pc_bhndlr,
   input  logic [2:0]             fetch_inc,
   output logic [PC_W-1:0]        pc,
   output logic                   fetch_valid,
   output logic                   redirect,
   output logic                   flush,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [PC_W-1:0] MAX_STEP = PC_W'(FETCH_WIDTH);

   state_t                   state, state_next;
   logic [PC_W-1:0]          pc_next;
   logic [PC_W-1:0]          step;
   logic                     fetch_valid_next;
   logic                     redirect_next;
   logic                     flush_next;
   logic [STALL_CNT_W-1:0]   stall_cnt_next;

   // Sequential step: out-of-range or zero fetch_inc falls back to a full fetch width.
   always_comb begin
      if (fetch_inc != 3'd0 && PC_W'(fetch_inc) <= MAX_STEP)
         step = PC_W'(fetch_inc);
      else
         step = MAX_STEP;
   end

   // Next-PC mux and registered-flag decode from the select code.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      pc_next          = pc;
      fetch_valid_next = 1'b0;
      redirect_next    = 1'b0;
      flush_next       = 1'b0;
      case (PC_select)
         3'd0: begin pc_next = pc_pred0;    fetch_valid_next = 1'b1; redirect_next = 1'b1; end
         3'd1: begin pc_next = pc_pred1;    fetch_valid_next = 1'b1; redirect_next = 1'b1; end
         3'd2: begin pc_next = pc_jump;     fetch_valid_next = 1'b1; redirect_next = 1'b1; end
         3'd3: begin
            pc_next          = pc_recovery;
            fetch_valid_next = 1'b1;
            redirect_next    = 1'b1;
            flush_next       = 1'b1;
         end
         3'd4: begin pc_next = pc_bhndlr;   fetch_valid_next = 1'b1; redirect_next = 1'b1; end
         3'd5: begin pc_next = pc + step;   fetch_valid_next = 1'b1; end
         3'd6: pc_next = pc;
         3'd7: pc_next = RESET_VEC;
      endcase
   end

   // BOOT/RUN/HOLD transitions: code 6 parks in HOLD, code 7 returns to BOOT.
   always_comb begin
      state_next = state;
      case (state)
         BOOT: begin
            if (PC_select == 3'd7)      state_next = BOOT;
            else if (PC_select == 3'd6) state_next = HOLD;
            else                        state_next = RUN;
         end
         RUN, HOLD: begin
            if (PC_select == 3'd6)      state_next = HOLD;
            else if (PC_select == 3'd7) state_next = BOOT;
            else                        state_next = RUN;
         end
         default: state_next = BOOT;
      endcase
   end

   // Hold-cycle counter: counts each edge that enters or stays in HOLD, sticks at all-ones.
   always_comb begin
      stall_cnt_next = stall_cnt;
      if (state_next == HOLD && stall_cnt != '1)
         stall_cnt_next = stall_cnt + 1'b1;
   end

   // State and output registers; rst wins over every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_VEC;
         fetch_valid <= 1'b0;
         redirect    <= 1'b0;
         flush       <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         fetch_valid <= fetch_valid_next;
         redirect    <= redirect_next;
         flush       <= flush_next;
         stall_cnt   <= stall_cnt_next;
      end
   end

endmodule

// File: tb/tb_pc_update.sv
// Scoreboard bench for pc_update. The driver applies one directed vector per
// cycle and queues the hand-computed result. A monitor pops the queue just
// after each rising edge and compares every output against that entry. The
// stall counter is narrowed to 4 bits so saturation is reachable quickly.
module tb_pc_update;

   localparam int CW = 4;

   typedef struct {
      logic [15:0]   pc;
      logic          fv;
      logic          red;
      logic          fl;
      logic [CW-1:0] st;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    PC_select;
   logic [15:0]   pc_pred0, pc_pred1, pc_jump, pc_recovery, pc_bhndlr;
   logic [2:0]    fetch_inc;
   logic [15:0]   pc;
   logic          fetch_valid, redirect, flush;
   logic [CW-1:0] stall_cnt;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   vec_id   = 0;

   pc_update #(.PC_W(16), .FETCH_WIDTH(4), .RESET_VEC(16'h0000), .STALL_CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .PC_select(PC_select),
      .pc_pred0(pc_pred0), .pc_pred1(pc_pred1), .pc_jump(pc_jump),
      .pc_recovery(pc_recovery), .pc_bhndlr(pc_bhndlr), .fetch_inc(fetch_inc),
      .pc(pc), .fetch_valid(fetch_valid), .redirect(redirect), .flush(flush),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, vec_id, act, req);
   endtask

   // One vector: drive inputs on the falling edge and queue the expected outputs
   // for the rising edge that follows. Flags follow directly from the select code.
   task automatic drive(input logic do_rst, input logic [2:0] sel, input logic [2:0] inc,
                        input logic [15:0] e_pc, input logic [CW-1:0] e_st);
      exp_t e;
      @(negedge clk);
      rst       = do_rst;
      PC_select = sel;
      fetch_inc = inc;
      e.pc  = e_pc;
      e.st  = e_st;
      e.fv  = !do_rst && (sel <= 3'd5);
      e.red = !do_rst && (sel <= 3'd4);
      e.fl  = !do_rst && (sel == 3'd3);
      exp_q.push_back(e);
   endtask

   // Monitor: compare the registered outputs shortly after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vec_id++;
         check("pc",          32'(pc),          32'(e.pc));
         check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
         check("redirect",    32'(redirect),    32'(e.red));
         check("flush",       32'(flush),       32'(e.fl));
         check("stall_cnt",   32'(stall_cnt),   32'(e.st));
      end
   end

   initial begin
      rst = 1'b1; PC_select = 3'd7; fetch_inc = 3'd0;
      pc_pred0 = 16'h1110; pc_pred1 = 16'h2220; pc_jump = 16'h0200;
      pc_recovery = 16'h0040; pc_bhndlr = 16'h4440;

      // T1: two reset cycles, then code 7 keeps BOOT at the reset vector
      drive(1, 3'd5, 3'd4, 16'h0000, 0);
      drive(1, 3'd0, 3'd4, 16'h0000, 0);
      drive(0, 3'd7, 3'd0, 16'h0000, 0);
      // T2: sequential fetch of 4, then steps of 1 and 3
      drive(0, 3'd5, 3'd4, 16'h0004, 0);
      drive(0, 3'd5, 3'd4, 16'h0008, 0);
      drive(0, 3'd5, 3'd4, 16'h000C, 0);
      drive(0, 3'd5, 3'd1, 16'h000D, 0);
      drive(0, 3'd5, 3'd3, 16'h0010, 0);
      // T4: five hold cycles, then a jump
      for (int i = 1; i <= 5; i++) drive(0, 3'd6, 3'd2, 16'h0010, CW'(i));
      drive(0, 3'd2, 3'd0, 16'h0200, 5);
      // T3: wrap-around and out-of-range increments
      pc_pred0 = 16'hFFFE;
      drive(0, 3'd0, 3'd0, 16'hFFFE, 5);
      drive(0, 3'd5, 3'd0, 16'h0002, 5);
      drive(0, 3'd5, 3'd7, 16'h0006, 5);
      drive(0, 3'd5, 3'd5, 16'h000A, 5);
      // T5: code-0 stream interrupted by recovery, then slot 1 and branch handler
      pc_pred0 = 16'h1110;
      drive(0, 3'd0, 3'd0, 16'h1110, 5);
      drive(0, 3'd0, 3'd0, 16'h1110, 5);
      drive(0, 3'd3, 3'd0, 16'h0040, 5);
      drive(0, 3'd1, 3'd0, 16'h2220, 5);
      drive(0, 3'd4, 3'd0, 16'h4440, 5);
      drive(0, 3'd0, 3'd0, 16'h1110, 5);
      // Back to BOOT, straight into HOLD, then resume from HOLD
      drive(0, 3'd7, 3'd0, 16'h0000, 5);
      drive(0, 3'd6, 3'd0, 16'h0000, 6);
      drive(0, 3'd5, 3'd2, 16'h0002, 6);
      // T6: hold long enough to saturate the counter at 15
      for (int i = 7; i <= 18; i++) drive(0, 3'd6, 3'd0, 16'h0002, CW'((i > 15) ? 15 : i));
      // Reset mid-HOLD with a redirect code present: reset must win
      drive(1, 3'd2, 3'd0, 16'h0000, 0);
      drive(0, 3'd6, 3'd0, 16'h0000, 1);

      // Let the monitor drain, bounded
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
